// File: rtl/asm_pkg.sv
// Shared types for the ASM done logger: FSM states, id/q width and the log entry layout.
package asm_pkg;

  localparam int unsigned ID_W     = 4;
  localparam int unsigned TS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Entry layout at the default timestamp width; the top re-declares it for its TS_W.
  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [TS_W_DEF-1:0] ts;
    logic [ID_W-1:0]     q;
  } entry_t;

endpackage

// File: rtl/asm_entry_fifo.sv
// Register-based FIFO for log entries; head is read combinationally from storage.
module asm_entry_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [ENTRY_W-1:0]       push_data_i,
  input  logic                     pop_i,
  output logic [ENTRY_W-1:0]       head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic               push_ok, pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
    if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/asm_done_logger.sv
// Times ASM runs (start to done) and queues {id, ts, q} records in a FIFO.
// Optional macro ASM_DONE_LOGGER_DROP_CNT_EN adds a saturating drop_cnt output.
module asm_done_logger
  import asm_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s,
  input  logic                   g,
  input  logic [ID_W-1:0]        q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TS_W-1:0]        out_ts,
  output logic [ID_W-1:0]        out_id,
  output logic [ID_W-1:0]        out_q,
  output logic [$clog2(DEPTH):0] level
`ifdef ASM_DONE_LOGGER_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int unsigned ENTRY_W = 2 * ID_W + TS_W;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] ts;
    logic [ID_W-1:0] q;
  } log_entry_t;

  state_e          state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            g_q;
  logic            push_req, push_ok, pop, full, empty;
  log_entry_t      push_entry, head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ts_q    <= '0;
      id_q    <= '0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      id_q    <= id_d;
      g_q     <= g;
    end
  end

  // A done edge in the same cycle as s dropping still completes the run.
  always_comb begin
    state_d  = state_q;
    ts_d     = ts_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = RUN;
          ts_d    = '0;
        end
      end
      RUN: begin
        if (g && !g_q) begin
          push_req = 1'b1;
          state_d  = HOLD;
        end else if (!s) begin
          state_d = IDLE;
        end else if (ts_q != '1) begin
          ts_d = ts_q + TS_W'(1);
        end
      end
      HOLD: begin
        if (!g) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop        = out_valid && out_ready;
  assign push_ok    = push_req && (!full || pop);
  assign id_d       = push_ok ? id_q + ID_W'(1) : id_q;
  assign push_entry = '{id: id_q, ts: ts_q, q: q};

  asm_entry_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level)
  );

  assign out_valid = !empty;
  assign out_ts    = head.ts;
  assign out_id    = head.id;
  assign out_q     = head.q;

`ifdef ASM_DONE_LOGGER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (push_req && !push_ok && drop_cnt_q != 8'hFF) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_asm_done_logger.sv
// Directed self-checking bench for asm_done_logger (DEPTH=4, TS_W=8).
module tb_asm_done_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       s;
  logic       g;
  logic [3:0] q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ts;
  logic [3:0] out_id;
  logic [3:0] out_q;
  logic [2:0] level;
`ifdef ASM_DONE_LOGGER_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  asm_done_logger #(.DEPTH(4), .TS_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .g         (g),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ts    (out_ts),
    .out_id    (out_id),
    .out_q     (out_q),
    .level     (level)
`ifdef ASM_DONE_LOGGER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_head(input string tag, input logic [3:0] id, input logic [7:0] ts,
                            input logic [3:0] qv);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_id"},    32'(out_id),    32'(id));
    check({tag, "_ts"},    32'(out_ts),    32'(ts));
    check({tag, "_q"},     32'(out_q),     32'(qv));
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_level"}, 32'(level),     32'd0);
  endtask

  // Start in cycle 0, raise g with q=qv in cycle n; returns right after the push edge.
  task automatic start_and_rise(input int n, input logic [3:0] qv);
    s = 1'b1;
    g = 1'b0;
    tick();
    repeat (n - 1) tick();
    g = 1'b1;
    q = qv;
    tick();
  endtask

  task automatic finish_run();
    g = 1'b0;
    s = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    s   = 1'b0;
    g   = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; s = 1'b0; g = 1'b0; q = 4'h0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    check_empty("rst");
    check("rst_ts", 32'(out_ts), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_q",  32'(out_q),  32'd0);

    // Single run, g rises at cycle 20, consumer ready
    out_ready = 1'b1;
    start_and_rise(20, 4'hA);
    check_head("run20", 4'd0, 8'd19, 4'hA);
    check("run20_level", 32'(level), 32'd1);
    finish_run();
    check_empty("run20_pop");

    // Five runs with consumer stalled: four kept, fifth dropped
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start_and_rise(3 + i, 4'(i + 1));
      finish_run();
    end
    check("full_level", 32'(level), 32'd4);
    check_head("full_head", 4'd0, 8'd2, 4'd1);
`ifdef ASM_DONE_LOGGER_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Full FIFO, push and pop in the same cycle
    s = 1'b1;
    tick();
    repeat (7) tick();
    g = 1'b1;
    q = 4'd6;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_level", 32'(level), 32'd4);
    check_head("pp_head", 4'd1, 8'd3, 4'd2);
    finish_run();

    // Drain in order; new entry must be at the tail with id 4
    out_ready = 1'b1;
    check_head("drain0", 4'd1, 8'd3, 4'd2);
    tick();
    check_head("drain1", 4'd2, 8'd4, 4'd3);
    tick();
    check_head("drain2", 4'd3, 8'd5, 4'd4);
    tick();
    check_head("drain3", 4'd4, 8'd7, 4'd6);
    tick();
    check_empty("drained");
    tick();
    check_empty("pop_empty");

    // Timestamp saturation and head stability under back-pressure
    out_ready = 1'b0;
    start_and_rise(300, 4'd3);
    check_head("sat", 4'd5, 8'hFF, 4'd3);
    tick();
    check_head("stall", 4'd5, 8'hFF, 4'd3);
    check("stall_level", 32'(level), 32'd1);
    out_ready = 1'b1;
    finish_run();
    check_empty("sat_pop");
    out_ready = 1'b0;

    // Abort: s falls at cycle 10, then g rises; nothing queued, id not consumed
    do_reset();
    s = 1'b1;
    tick();
    repeat (9) tick();
    s = 1'b0;
    tick();
    g = 1'b1;
    tick();
    g = 1'b0;
    tick();
    check_empty("abort");
    start_and_rise(5, 4'd7);
    check_head("after_abort", 4'd0, 8'd4, 4'd7);
    finish_run();

    // Reset mid-RUN with two entries queued
    start_and_rise(3, 4'd8);
    check("two_level", 32'(level), 32'd2);
    finish_run();
    s = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    s = 1'b0;
    tick();
    rst = 1'b1;
    check_empty("midrst");
    check("midrst_ts", 32'(out_ts), 32'd0);
    check("midrst_id", 32'(out_id), 32'd0);
`ifdef ASM_DONE_LOGGER_DROP_CNT_EN
    check("midrst_drop", 32'(drop_cnt), 32'd0);
`endif
    start_and_rise(4, 4'd9);
    check_head("post_rst", 4'd0, 8'd3, 4'd9);
    check("post_rst_level", 32'(level), 32'd1);
    finish_run();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
